// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Bundle widths, EX/MEM field offsets and slot opcodes shared by
//               the MIPS pipeline boundary registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int unsigned MAX_DEPTH      = 4;

    // IF/ID carries no decoded control yet; one reserved bit keeps ports legal.
    localparam int unsigned IF_ID_CTRL_W   = 1;
    localparam int unsigned IF_ID_DATA_W   = 2 * 32;
    localparam int unsigned ID_EX_CTRL_W   = 15;
    localparam int unsigned ID_EX_DATA_W   = 5 * 32 + 3 * 5;
    localparam int unsigned EX_MEM_CTRL_W  = 9;
    localparam int unsigned EX_MEM_DATA_W  = 7 * 32 + 5 + 1;
    localparam int unsigned MEM_WB_CTRL_W  = 3;
    localparam int unsigned MEM_WB_DATA_W  = 3 * 32 + 5;

    localparam int unsigned EX_MEM_REGWRITE_BIT  = 0;
    localparam int unsigned EX_MEM_MEMWRITE_BIT  = 1;
    localparam int unsigned EX_MEM_MEMTOREG_LSB  = 2;
    localparam int unsigned EX_MEM_MEMTOREG_MSB  = 3;
    localparam int unsigned EX_MEM_MEMREAD_BIT   = 4;
    localparam int unsigned EX_MEM_BRANCHNE_BIT  = 5;
    localparam int unsigned EX_MEM_BRANCHEQ_BIT  = 6;
    localparam int unsigned EX_MEM_JUMP_LSB      = 7;
    localparam int unsigned EX_MEM_JUMP_MSB      = 8;

    typedef struct packed {
        logic [1:0] jump;
        logic       branch_eq;
        logic       branch_ne;
        logic       mem_read;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic       reg_write;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        SLOT_HOLD = 2'd0,
        SLOT_LOAD = 2'd1,
        SLOT_KILL = 2'd2
    } slot_op_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One {valid, ctrl, data} pipeline register, captured on the
//               falling clock edge, with load / hold / kill control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 230
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  slot_op_t          op_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Kill clears valid/ctrl but leaves data alone; a load of an invalid
    // entry zeroes ctrl so no write enable can leak downstream.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        case (op_i)
            SLOT_LOAD: begin
                valid_d = valid_i;
                ctrl_d  = valid_i ? ctrl_i : '0;
                data_d  = data_i;
            end
            SLOT_KILL: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline boundary register: DEPTH cascaded slots
//               with stall, flush, occupancy and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  bubble_count
);

    slot_op_t          slot_op;
    logic              slot_valid [DEPTH];
    logic [CTRL_W-1:0] slot_ctrl  [DEPTH];
    logic [DATA_W-1:0] slot_data  [DEPTH];

    // Flush outranks stall; all slots share one opcode per edge.
    always_comb begin
        slot_op = SLOT_LOAD;
        if (flush) begin
            slot_op = SLOT_KILL;
        end else if (stall) begin
            slot_op = SLOT_HOLD;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic [DATA_W-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = valid_in;
            assign src_ctrl  = ctrl_in;
            assign src_data  = data_in;
        end else begin : g_chain
            assign src_valid = slot_valid[k-1];
            assign src_ctrl  = slot_ctrl[k-1];
            assign src_data  = slot_data[k-1];
        end

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk_i    (clk),
            .reset_ni (reset),
            .op_i     (slot_op),
            .valid_i  (src_valid),
            .ctrl_i   (src_ctrl),
            .data_i   (src_data),
            .valid_o  (slot_valid[k]),
            .ctrl_o   (slot_ctrl[k]),
            .data_o   (slot_data[k])
        );
    end

    logic             bubble_inc;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    assign bubble_inc = flush | (~stall & ~valid_in);

    always_comb begin
        bubble_count_d = bubble_count_q;
        if (bubble_inc && (bubble_count_q != {CNT_W{1'b1}})) begin
            bubble_count_d = bubble_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(slot_valid[i]);
        end
    end

    assign valid_out    = slot_valid[DEPTH-1];
    assign ctrl_out     = slot_valid[DEPTH-1] ? slot_ctrl[DEPTH-1] : '0;
    assign data_out     = slot_data[DEPTH-1];
    assign bubble_count = bubble_count_q;

endmodule : pipe_stage_reg
`default_nettype wire
